// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard/scoreboard unit: exception codes, redirect
// vector, forward-select encoding and register-index width.
package hazard_scoreboard_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regIdx_t;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam logic [31:0] EXC_VEC_DEFAULT = 32'hBFC0_0380;

    // Forward select: 0 reads the register file, k+1 takes producer stage k.
    localparam int FWD_SEL_RF = 0;

endpackage

// File: rtl/hazard_scoreboard_slot.sv
// One scoreboard entry tracking an outstanding long-latency register write
// with a free-running countdown to its writeback.
module long_slot
    import hazard_scoreboard_pkg::*;
#(
    parameter int LAT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             alloc,
    input  logic [REG_W-1:0] allocReg,
    input  logic [LAT_W-1:0] allocLat,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] wregD,
    output logic             valid,
    output logic             retiring,
    output logic             hitRs,
    output logic             hitRt,
    output logic             hitWreg
);

    regIdx_t          slotReg;
    logic [LAT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid   <= 1'b0;
            slotReg <= '0;
            cnt     <= '0;
        end else if (alloc) begin
            valid   <= 1'b1;
            slotReg <= allocReg;
            cnt     <= allocLat;
        end else if (valid) begin
            valid <= !retiring;
            cnt   <= cnt - 1'b1;
        end
    end

    // A retiring entry still reports hits: its value only reaches W forwarding next cycle.
    assign retiring = valid && (cnt == LAT_W'(1));
    assign hitRs    = valid && (slotReg == rsD);
    assign hitRt    = valid && (slotReg == rtD);
    assign hitWreg  = valid && (slotReg == wregD);

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: N-stage forward select, long-latency write scoreboard,
// stall/flush generation and a registered exception redirect.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int          FWD_STAGES = 3,
    parameter int          LONG_SLOTS = 2,
    parameter int          LAT_W      = 6,
    parameter logic [31:0] EXC_VEC    = EXC_VEC_DEFAULT,
    parameter logic [31:0] ERET_CODE  = EXC_ERET
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic [REG_W-1:0]                    rs_d,
    input  logic [REG_W-1:0]                    rt_d,
    input  logic                                use_rs_d,
    input  logic                                use_rt_d,
    input  logic                                long_d,
    input  logic [REG_W-1:0]                    wreg_d,
    input  logic [REG_W*FWD_STAGES-1:0]         fwd_wreg,
    input  logic [FWD_STAGES-1:0]               fwd_we,
    input  logic [FWD_STAGES-1:0]               fwd_rdy,
    input  logic                                issue_long_e,
    input  logic [REG_W-1:0]                    issue_reg_e,
    input  logic [LAT_W-1:0]                    issue_lat_e,
    input  logic [31:0]                         excepttype_m,
    input  logic [31:0]                         epc_m,
    input  logic                                inst_stall,
    input  logic                                data_stall,
    output logic [$clog2(FWD_STAGES+1)-1:0]     fwd_sel_a_d,
    output logic [$clog2(FWD_STAGES+1)-1:0]     fwd_sel_b_d,
    output logic                                stall_f,
    output logic                                stall_d,
    output logic                                stall_e,
    output logic                                stall_m,
    output logic                                stall_w,
    output logic                                flush_f,
    output logic                                flush_d,
    output logic                                flush_e,
    output logic                                flush_m,
    output logic                                flush_w,
    output logic                                newpc_valid,
    output logic [31:0]                         newpc,
    output logic [LONG_SLOTS-1:0]               slots_busy
);

    localparam int SEL_W = $clog2(FWD_STAGES+1);

    logic [LONG_SLOTS-1:0] slotValid, slotRetiring, slotHitRs, slotHitRt, slotHitWreg, allocVec;
    logic [SEL_W-1:0]      selA, selB;
    logic                  matchA, matchB, rdyA, rdyB, useA, useB;
    logic                  hzOpA, hzOpB, hzLong, hz, exc, frontStall, allocReq, found;

    assign useA = use_rs_d && (rs_d != '0);
    assign useB = use_rt_d && (rt_d != '0);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        selA   = SEL_W'(FWD_SEL_RF);
        selB   = SEL_W'(FWD_SEL_RF);
        matchA = 1'b0;
        matchB = 1'b0;
        rdyA   = 1'b1;
        rdyB   = 1'b1;
        // Walk oldest to youngest so the youngest matching producer wins.
        for (int k = FWD_STAGES-1; k >= 0; k--) begin
            if (useA && fwd_we[k] && (fwd_wreg[REG_W*k +: REG_W] == rs_d)) begin
                matchA = 1'b1;
                selA   = SEL_W'(k+1);
                rdyA   = fwd_rdy[k];
            end
            if (useB && fwd_we[k] && (fwd_wreg[REG_W*k +: REG_W] == rt_d)) begin
                matchB = 1'b1;
                selB   = SEL_W'(k+1);
                rdyB   = fwd_rdy[k];
            end
        end
    end

    assign fwd_sel_a_d = selA;
    assign fwd_sel_b_d = selB;

    assign hzOpA  = matchA ? !rdyA : (useA && |slotHitRs);
    assign hzOpB  = matchB ? !rdyB : (useB && |slotHitRt);
    assign hzLong = long_d && ((&slotValid && !(|slotRetiring)) || |slotHitWreg);
    assign hz     = hzOpA || hzOpB || hzLong;

    assign exc        = (excepttype_m != '0) && !data_stall;
    assign frontStall = hz || inst_stall || data_stall;

    assign stall_f = !exc && frontStall;
    assign stall_d = !exc && frontStall;
    assign stall_e = !exc && data_stall;
    assign stall_m = !exc && data_stall;
    assign stall_w = 1'b0;

    assign flush_f = exc;
    assign flush_d = exc;
    assign flush_e = exc || (hz && !data_stall);
    assign flush_m = exc;
    assign flush_w = exc || data_stall;

    assign allocReq = issue_long_e && !stall_e && !exc;

    always_comb begin
        allocVec = '0;
        found    = 1'b0;
        for (int s = 0; s < LONG_SLOTS; s++) begin
            if (!slotValid[s] && !found) begin
                allocVec[s] = allocReq;
                found       = 1'b1;
            end
        end
    end

    for (genvar s = 0; s < LONG_SLOTS; s++) begin : gSlot
        long_slot #(.LAT_W(LAT_W)) uSlot (
            .clk      (clk),
            .resetn   (resetn),
            .alloc    (allocVec[s]),
            .allocReg (issue_reg_e),
            .allocLat (issue_lat_e),
            .rsD      (rs_d),
            .rtD      (rt_d),
            .wregD    (wreg_d),
            .valid    (slotValid[s]),
            .retiring (slotRetiring[s]),
            .hitRs    (slotHitRs[s]),
            .hitRt    (slotHitRt[s]),
            .hitWreg  (slotHitWreg[s])
        );
    end

    assign slots_busy = slotValid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            newpc_valid <= 1'b0;
            newpc       <= '0;
        end else begin
            newpc_valid <= exc;
            if (exc) newpc <= (excepttype_m == ERET_CODE) ? epc_m : EXC_VEC;
        end
    end

    // Issuing into a full table is a protocol violation by the E stage.
    aFullIssue: assert property (@(posedge clk) disable iff (!resetn) !(allocReq && &slotValid));

endmodule
